wb_image_loader: RTL and testbench

Wishbone classic initiator that fills the user-area 2 kB program SRAM from a byte stream before the TMS1x00 core runs. It sits between a byte source (pin-level shift-in logic or a test harness) and the user-project Wishbone slave port. Bytes are packed little-endian into 32-bit words and written to sequential word addresses, with timeout detection and partial-word flush.

---
 rtl/wb_image_loader.sv | 134 +++++++++++++
 tb/tb_wb_image_loader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_image_loader.sv
// wb_image_loader: Wishbone classic initiator that fills program SRAM from a byte stream.
// Bytes pack little-endian into words; a partial word is flushed on byte_last.
module wb_image_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          WORDS     = 512,
   parameter int          TIMEOUT   = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   input  logic        byte_last,
   output logic        byte_ready,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   input  logic        wbm_ack_i,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [9:0]  word_count
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_WRITE   = 3'd2;
   localparam logic [2:0] S_DONE    = 3'd3;
   localparam logic [2:0] S_ERROR   = 3'd4;

   localparam logic [9:0] WORDS_MAX = 10'(WORDS);
   localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

   logic [2:0] state;
   logic [1:0] lane;
   logic [7:0] tmo;
   logic       last_word;
   logic [9:0] wc_next;
   logic       xfer;

   assign wc_next = word_count + 10'd1;
   assign xfer    = byte_valid & byte_ready;

   // The assembly register doubles as the bus data output so it stays
   // frozen for the whole strobe without a second copy.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state      <= S_IDLE;
         lane       <= 2'd0;
         tmo        <= 8'd0;
         last_word  <= 1'b0;
         byte_ready <= 1'b0;
         wbm_cyc_o  <= 1'b0;
         wbm_stb_o  <= 1'b0;
         wbm_we_o   <= 1'b0;
         wbm_adr_o  <= 32'd0;
         wbm_dat_o  <= 32'd0;
         wbm_sel_o  <= 4'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         word_count <= 10'd0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state      <= S_COLLECT;
                  lane       <= 2'd0;
                  busy       <= 1'b1;
                  byte_ready <= 1'b1;
                  done       <= 1'b0;
                  error      <= 1'b0;
                  word_count <= 10'd0;
                  wbm_adr_o  <= BASE_ADDR;
                  wbm_dat_o  <= 32'd0;
                  wbm_sel_o  <= 4'd0;
               end
            end
            S_COLLECT: begin
               if (xfer) begin
                  wbm_dat_o[{lane, 3'b000} +: 8] <= byte_in;
                  wbm_sel_o[lane] <= 1'b1;
                  lane <= lane + 2'd1;
                  if (lane == 2'd3 || byte_last) begin
                     state      <= S_WRITE;
                     last_word  <= byte_last;
                     tmo        <= 8'd0;
                     byte_ready <= 1'b0;
                     wbm_cyc_o  <= 1'b1;
                     wbm_stb_o  <= 1'b1;
                     wbm_we_o   <= 1'b1;
                  end
               end
            end
            S_WRITE: begin
               if (wbm_ack_i) begin
                  wbm_cyc_o  <= 1'b0;
                  wbm_stb_o  <= 1'b0;
                  wbm_we_o   <= 1'b0;
                  word_count <= wc_next;
                  lane       <= 2'd0;
                  wbm_adr_o  <= wbm_adr_o + 32'd4;
                  wbm_dat_o  <= 32'd0;
                  wbm_sel_o  <= 4'd0;
                  if (last_word || wc_next == WORDS_MAX) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state      <= S_COLLECT;
                     byte_ready <= 1'b1;
                  end
               end else if (tmo == TMO_LAST) begin
                  state     <= S_ERROR;
                  busy      <= 1'b0;
                  error     <= 1'b1;
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  wbm_we_o  <= 1'b0;
               end else begin
                  tmo <= tmo + 8'd1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_image_loader.sv
// tb_wb_image_loader: table-driven and randomized checks of wb_image_loader
// against a word-packing model of the byte stream.
module tb_wb_image_loader;

   localparam int          WORDS   = 3;
   localparam int          TIMEOUT = 8;
   localparam logic [31:0] BASE    = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        wb_rst_i;
   logic        start;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_last;
   logic        byte_ready;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [3:0]  wbm_sel_o;
   logic        wbm_ack_i;
   logic        busy;
   logic        done;
   logic        error;
   logic [9:0]  word_count;

   always #5 clk = ~clk;

   wb_image_loader #(
      .BASE_ADDR(BASE),
      .WORDS(WORDS),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .wb_clk_i(clk),
      .wb_rst_i(wb_rst_i),
      .start(start),
      .byte_in(byte_in),
      .byte_valid(byte_valid),
      .byte_last(byte_last),
      .byte_ready(byte_ready),
      .wbm_cyc_o(wbm_cyc_o),
      .wbm_stb_o(wbm_stb_o),
      .wbm_we_o(wbm_we_o),
      .wbm_adr_o(wbm_adr_o),
      .wbm_dat_o(wbm_dat_o),
      .wbm_sel_o(wbm_sel_o),
      .wbm_ack_i(wbm_ack_i),
      .busy(busy),
      .done(done),
      .error(error),
      .word_count(word_count)
   );

   int checks = 0;
   int fails  = 0;

   task automatic check(input string name, input logic [127:0] got,
                        input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
   } wr_t;

   typedef struct {
      logic [127:0] data;
      int           nb;
      bit           last;
      int           wt;
      logic [31:0]  dat0;
      logic [3:0]   sel0;
      int           wc;
      bit           err;
   } vec_t;

   wr_t got_q[$];
   wr_t exp_q[$];
   int  accepted;
   int  cycles;
   int  max_stb;
   bit  timed_out;
   bit  stable_ok;
   bit  ready_ok;
   bit  post_ok;

   // Reference: chop the stream into 4-byte words, stop at byte_last,
   // at the word limit, or at the first write when the slave never acks.
   task automatic model(input logic [127:0] data, input int nb,
                        input bit has_last, input int wt,
                        output int exp_acc, output int exp_wc,
                        output bit exp_err, output int exp_cyc);
      int  pos;
      int  w;
      int  n;
      wr_t e;
      pos = 0;
      w = 0;
      exp_err = 0;
      exp_cyc = 1;
      exp_q.delete();
      while (w < WORDS) begin
         n = (nb - pos < 4) ? nb - pos : 4;
         e.adr = BASE + 32'(4 * w);
         e.dat = 32'd0;
         e.sel = 4'd0;
         for (int i = 0; i < n; i++) begin
            e.dat[8*i +: 8] = data[8*(pos+i) +: 8];
            e.sel[i] = 1'b1;
         end
         pos += n;
         if (wt < 0) begin
            exp_err = 1;
            exp_cyc += n + TIMEOUT;
            break;
         end
         exp_q.push_back(e);
         w++;
         exp_cyc += n + 1 + wt;
         if (has_last && pos == nb) break;
      end
      exp_acc = pos;
      exp_wc = w;
   endtask

   task automatic run(input logic [127:0] data, input int nb,
                      input bit has_last, input int wt, input bit gaps,
                      input int abort_stb);
      int  idx;
      int  stbc;
      int  k;
      wr_t snap;
      idx = 0;
      stbc = 0;
      k = 0;
      snap = '{32'd0, 32'd0, 4'd0};
      got_q.delete();
      max_stb = 0;
      timed_out = 0;
      stable_ok = 1;
      ready_ok = 1;
      post_ok = 1;
      @(negedge clk);
      start = 1'b1;
      byte_valid = 1'b0;
      wbm_ack_i = 1'b0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         k++;
         start = 1'b0;
         if (k == 1)
            check("start_resp", {busy, byte_ready, done, error, word_count},
                  {4'b1100, 10'd0});
         if (done || error) break;
         if (k > 3000) begin
            timed_out = 1;
            break;
         end
         if (wbm_stb_o) begin
            stbc++;
            if (stbc == 1)
               snap = '{wbm_adr_o, wbm_dat_o, wbm_sel_o};
            else if (wbm_adr_o !== snap.adr || wbm_dat_o !== snap.dat ||
                     wbm_sel_o !== snap.sel)
               stable_ok = 0;
            if (byte_ready || !wbm_cyc_o || !wbm_we_o) ready_ok = 0;
            if (stbc > max_stb) max_stb = stbc;
            if (abort_stb > 0 && stbc == abort_stb) break;
            wbm_ack_i = (wt >= 0 && stbc == wt + 1);
            if (wbm_ack_i) got_q.push_back(snap);
         end else begin
            stbc = 0;
            wbm_ack_i = 1'($urandom);
         end
         if (idx < nb && (!gaps || $urandom_range(0, 3) != 0)) begin
            byte_valid = 1'b1;
            byte_in = data[8*idx +: 8];
            byte_last = has_last && idx == nb - 1;
            if (byte_ready) idx++;
         end else begin
            byte_valid = 1'b0;
            byte_in = 8'($urandom);
            byte_last = 1'($urandom);
         end
         if (busy && $urandom_range(0, 2) == 0) start = 1'b1;
      end
      cycles = k;
      accepted = idx;
      if (abort_stb == 0) begin
         wbm_ack_i = 1'b0;
         for (int j = 0; j < 4; j++) begin
            byte_valid = (idx < nb);
            byte_in = (idx < nb) ? data[8*idx +: 8] : 8'd0;
            byte_last = 1'b0;
            @(negedge clk);
            if (byte_ready || busy || wbm_stb_o) post_ok = 0;
         end
         byte_valid = 1'b0;
      end
   endtask

   task automatic do_vec(input string tag, input vec_t v, input bit gaps);
      int  e_acc;
      int  e_wc;
      bit  e_err;
      int  e_cyc;
      int  n;
      model(v.data, v.nb, v.last, v.wt, e_acc, e_wc, e_err, e_cyc);
      run(v.data, v.nb, v.last, v.wt, gaps, 0);
      check({tag, "_bound"}, 128'(timed_out), 128'(0));
      check({tag, "_wc"}, 128'(word_count), 128'(e_wc));
      check({tag, "_flags"}, {done, error}, {!e_err, e_err});
      check({tag, "_accepted"}, 128'(accepted), 128'(e_acc));
      check({tag, "_nwrites"}, 128'(got_q.size()), 128'(exp_q.size()));
      check({tag, "_stable"}, 128'(stable_ok), 128'(1));
      check({tag, "_ready_in_write"}, 128'(ready_ok), 128'(1));
      check({tag, "_idle_after"}, 128'(post_ok), 128'(1));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_w%0d", tag, i),
               {got_q[i].adr, got_q[i].dat, got_q[i].sel},
               {exp_q[i].adr, exp_q[i].dat, exp_q[i].sel});
      if (!gaps)
         check({tag, "_cycles"}, 128'(cycles), 128'(e_cyc));
      if (e_err)
         check({tag, "_stb_len"}, 128'(max_stb), 128'(TIMEOUT));
      if (v.wc >= 0)
         check({tag, "_tbl_wc"}, 128'(word_count), 128'(v.wc));
      if (!v.err && got_q.size() > 0)
         check({tag, "_tbl_w0"}, {got_q[0].dat, got_q[0].sel},
               {v.dat0, v.sel0});
   endtask

   vec_t tbl[9];
   vec_t rv;

   initial begin
      tbl[0] = '{128'h88776655_44332211, 8, 1, 0, 32'h4433_2211, 4'hF, 2, 0};
      tbl[1] = '{128'hBBAA, 2, 1, 0, 32'h0000_BBAA, 4'h3, 1, 0};
      tbl[2] = '{128'hDEADBEEF, 4, 1, 5, 32'hDEAD_BEEF, 4'hF, 1, 0};
      tbl[3] = '{128'h5A, 1, 1, 7, 32'h0000_005A, 4'h1, 1, 0};
      tbl[4] = '{128'h44332211, 4, 1, -1, 32'h0, 4'h0, 0, 1};
      tbl[5] = '{128'hC3C2C1_B4B3B2B1, 7, 1, 2, 32'hB4B3_B2B1, 4'hF, 2, 0};
      tbl[6] = '{128'h0F0E0D0C_0B0A0908_07060504_03020100, 16, 0, 0,
                 32'h0302_0100, 4'hF, 3, 0};
      tbl[7] = '{128'h0B0A0908_07060504_03020100, 12, 1, 1,
                 32'h0302_0100, 4'hF, 3, 0};
      tbl[8] = '{128'h9988, 2, 1, -1, 32'h0, 4'h0, 0, 1};

      wb_rst_i = 1'b1;
      start = 1'b0;
      byte_in = 8'd0;
      byte_valid = 1'b0;
      byte_last = 1'b0;
      wbm_ack_i = 1'b0;
      #1;
      check("reset_outputs",
            {byte_ready, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
             wbm_sel_o, busy, done, error, word_count}, 128'(0));
      repeat (3) @(negedge clk);
      wb_rst_i = 1'b0;
      @(negedge clk);
      check("idle_outputs", {byte_ready, busy, wbm_stb_o}, 128'(0));

      for (int i = 0; i < 9; i++)
         do_vec($sformatf("vec%0d", i), tbl[i], 0);

      // reset while the strobe is up
      run(128'h88776655_44332211, 8, 1, -1, 0, 3);
      check("stb_before_rst", {wbm_cyc_o, wbm_stb_o}, 128'(3));
      wb_rst_i = 1'b1;
      #1;
      check("rst_mid_write",
            {byte_ready, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
             wbm_sel_o, busy, done, error, word_count}, 128'(0));
      @(negedge clk);
      wb_rst_i = 1'b0;
      wbm_ack_i = 1'b0;
      byte_valid = 1'b0;
      @(negedge clk);
      do_vec("after_rst", tbl[0], 0);

      for (int i = 0; i < 25; i++) begin
         rv.nb = $urandom_range(1, 16);
         rv.last = 1'($urandom);
         if (!rv.last && rv.nb < 4 * WORDS) rv.nb = 16;
         rv.data = {$urandom, $urandom, $urandom, $urandom};
         rv.wt = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 7));
         rv.dat0 = 32'd0;
         rv.sel0 = 4'd0;
         rv.wc = -1;
         rv.err = 1;
         do_vec($sformatf("rnd%0d", i), rv, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
